// File: rtl/keypad_debounce_scanner_if.sv
// Keypad scanner signal bundle: column sense in, row drive and decoded key out.
// The scanner side uses the master modport; the keypad/consumer side uses slave.
interface keypad_debounce_scanner_if;
   logic [3:0] columns;   // active-low column levels, already synchronized
   logic [3:0] rows;      // active-low one-hot row drive
   logic [3:0] value;     // hex code of the last accepted key
   logic       enable;    // one-cycle strobe when value updates

   modport master (
      input  columns,
      output rows,
      output value,
      output enable
   );

   modport slave (
      output columns,
      input  rows,
      input  value,
      input  enable
   );
endinterface

// File: rtl/keypad_debounce_scanner.sv
// 4x4 matrix keypad scanner with press and release debouncing.
// Rows are driven low one at a time; a single closed column on the driven
// row freezes the scan while the key is debounced, reported once, and then
// debounced again on release before scanning resumes on the next row.
module keypad_debounce_scanner #(
   parameter int SCAN_DIV        = 48000,   // cycles per row dwell
   parameter int DEBOUNCE_CYCLES = 960000   // cycles a level must hold (>= 2)
) (
   input  logic                       clk,
   input  logic                       reset,   // asynchronous, active-low
   keypad_debounce_scanner_if.master  kp
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   // Last dwell cycle of a row: the only cycle in which columns are sampled.
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   // The level has already been seen once on entry to a debounce state, so
   // the counter terminates one short of DEBOUNCE_CYCLES; this makes the
   // press strobe land exactly DEBOUNCE_CYCLES after the sample cycle.
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 2);

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE_PRESS,
      HELD,
      DEBOUNCE_RELEASE
   } state_t;

   state_t           state_q;
   logic [1:0]       row_q;
   logic [1:0]       col_q;
   logic [3:0]       rows_q;
   logic [3:0]       value_q;
   logic             enable_q;
   logic [DIV_W-1:0] div_q;
   logic [DEB_W-1:0] deb_q;

   logic [3:0] col_low;
   logic       one_low;
   logic [1:0] low_idx;
   logic       sel_low;

   assign col_low = ~kp.columns;
   // Exactly one closed column: non-zero and a power of two.
   assign one_low = (col_low != 4'd0) && ((col_low & (col_low - 4'd1)) == 4'd0);
   // Only the latched column matters once a key is captured.
   assign sel_low = col_low[col_q];

   // Encode the closed column index (meaningful only when one_low is set).
   always_comb begin
      low_idx = 2'd0;
      for (int k = 0; k < 4; k++) begin
         if (col_low[k]) begin
            low_idx = 2'(k);
         end
      end
   end

   // Active-low one-hot row drive for a row index.
   function automatic logic [3:0] row_drive(input logic [1:0] r);
      return ~(4'b0001 << r);
   endfunction

   // Keypad legend: row r, column c to hex code.
   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'hE;
         4'b11_01: code = 4'h0;
         4'b11_10: code = 4'hF;
         default:  code = 4'hD;
      endcase
      return code;
   endfunction

   // Scan/debounce state machine with all outputs registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= SCAN;
         row_q    <= 2'd0;
         col_q    <= 2'd0;
         rows_q   <= 4'b1110;
         value_q  <= 4'h0;
         enable_q <= 1'b0;
         div_q    <= '0;
         deb_q    <= '0;
      end else begin
         enable_q <= 1'b0;
         case (state_q)
            SCAN: begin
               if (div_q == DIV_LAST) begin
                  div_q <= '0;
                  if (one_low) begin
                     // Freeze on this row and debounce the single closure.
                     col_q   <= low_idx;
                     deb_q   <= '0;
                     state_q <= DEBOUNCE_PRESS;
                  end else begin
                     // Open or ghosted (multi-key) row: move on (2-bit wrap).
                     row_q  <= row_q + 2'd1;
                     rows_q <= row_drive(row_q + 2'd1);
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end

            DEBOUNCE_PRESS: begin
               if (!sel_low) begin
                  // Bounce: abandon and give the next row a fresh dwell.
                  deb_q   <= '0;
                  div_q   <= '0;
                  row_q   <= row_q + 2'd1;
                  rows_q  <= row_drive(row_q + 2'd1);
                  state_q <= SCAN;
               end else if (deb_q == DEB_LAST) begin
                  value_q  <= key_code(row_q, col_q);
                  enable_q <= 1'b1;
                  deb_q    <= '0;
                  state_q  <= HELD;
               end else begin
                  deb_q <= deb_q + 1'b1;
               end
            end

            HELD: begin
               if (!sel_low) begin
                  deb_q   <= '0;
                  state_q <= DEBOUNCE_RELEASE;
               end
            end

            DEBOUNCE_RELEASE: begin
               if (sel_low) begin
                  // Release bounce: still the same press, no new strobe.
                  deb_q   <= '0;
                  state_q <= HELD;
               end else if (deb_q == DEB_LAST) begin
                  deb_q   <= '0;
                  div_q   <= '0;
                  row_q   <= row_q + 2'd1;
                  rows_q  <= row_drive(row_q + 2'd1);
                  state_q <= SCAN;
               end else begin
                  deb_q <= deb_q + 1'b1;
               end
            end

            default: begin
               state_q <= SCAN;
            end
         endcase
      end
   end

   assign kp.rows   = rows_q;
   assign kp.value  = value_q;
   assign kp.enable = enable_q;

endmodule

// File: tb/tb_keypad_debounce_scanner.sv
// Directed bench for keypad_debounce_scanner (SCAN_DIV=4, DEBOUNCE_CYCLES=8).
// A keypad model closes the chosen key's column when its row is driven; each
// test pushes the expected strobe (value, cycle after reset release) to a
// scoreboard that the per-cycle monitor pops on every enable.
module tb_keypad_debounce_scanner;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   keypad_debounce_scanner_if kp_if ();

   keypad_debounce_scanner #(
      .SCAN_DIV        (4),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .kp    (kp_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] val;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         cur      = 0;       // cycles since reset release
   bit         key_on   = 1'b0;
   int         key_r    = 0;
   int         key_c    = 0;
   logic [3:0] extra_low = 4'h0;   // columns forced low regardless of rows
   logic       prev_enable = 1'b0;
   logic [3:0] prev_value  = 4'h0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cur);
      end
   endtask

   // Drive this cycle's columns from the keypad model and monitor outputs.
   task automatic service();
      logic [3:0] col;
      exp_t       e;
      col = 4'hF;
      if (key_on && kp_if.rows[key_r] == 1'b0) col[key_c] = 1'b0;
      col = col & ~extra_low;
      kp_if.columns = col;

      if (prev_enable) check_eq("enable_single", {31'd0, kp_if.enable}, 32'd0);
      if (kp_if.enable) begin
         $display("[TB] strobe value=%h at cycle %0d", kp_if.value, cur);
         if (sb.size() == 0) begin
            check_eq("enable_unexpected", {31'd0, kp_if.enable}, 32'd0);
         end else begin
            e = sb.pop_front();
            check_eq("key_value", {28'd0, kp_if.value}, {28'd0, e.val});
            check_eq("key_cycle", cur, e.cyc);
         end
      end else if (kp_if.value !== prev_value) begin
         check_eq("value_hold", {28'd0, kp_if.value}, {28'd0, prev_value});
      end
      prev_enable = kp_if.enable;
      prev_value  = kp_if.value;
   endtask

   // Advance to the negedge of cycle n, servicing every cycle passed.
   task automatic run_to(input int n);
      while (cur < n) begin
         service();
         @(negedge clk);
         cur++;
      end
   endtask

   task automatic check_rows(input int n, input logic [3:0] exp);
      run_to(n);
      check_eq($sformatf("rows@%0d", n), {28'd0, kp_if.rows}, {28'd0, exp});
   endtask

   task automatic check_outputs_reset(input string tag);
      check_eq({tag, "_rows"},   {28'd0, kp_if.rows},   32'h0000000E);
      check_eq({tag, "_value"},  {28'd0, kp_if.value},  32'd0);
      check_eq({tag, "_enable"}, {31'd0, kp_if.enable}, 32'd0);
   endtask

   // Assert reset at a negedge, check the asynchronous response, then release.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      key_on = 1'b0;
      extra_low = 4'h0;
      kp_if.columns = 4'hF;
      #1;
      check_outputs_reset("reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      cur = 0;
      prev_enable = 1'b0;
      prev_value  = 4'h0;
   endtask

   task automatic press(input int r, input int c);
      key_r = r;
      key_c = c;
      key_on = 1'b1;
   endtask

   task automatic end_test(input string name);
      check_eq({name, "_pending"}, sb.size(), 32'd0);
      $display("[TB] %s done at cycle %0d", name, cur);
   endtask

   initial begin
      kp_if.columns = 4'hF;

      // Idle scan: every row gets a 4-cycle dwell, nothing is reported.
      do_reset();
      check_rows(0,  4'b1110);
      check_rows(4,  4'b1101);
      check_rows(8,  4'b1011);
      check_rows(12, 4'b0111);
      check_rows(16, 4'b1110);
      run_to(24);
      check_eq("idle_value", {28'd0, kp_if.value}, 32'd0);
      end_test("idle_scan");

      // r2c1 held: sample at cycle 11, strobe at 19, rows frozen until the
      // 8-cycle release completes at cycle 47.
      do_reset();
      press(2, 1);
      sb.push_back('{val: 4'h8, cyc: 19});
      check_rows(30, 4'b1011);
      run_to(40);
      key_on = 1'b0;
      check_rows(47, 4'b1011);
      check_rows(48, 4'b0111);
      run_to(56);
      check_eq("r2c1_value", {28'd0, kp_if.value}, 32'h8);
      end_test("press_r2c1");

      // r0c3 closed for only 5 cycles: rejected, scan resumes on row 1.
      do_reset();
      press(0, 3);
      run_to(5);
      key_on = 1'b0;
      check_rows(5,  4'b1110);
      check_rows(6,  4'b1101);
      check_rows(9,  4'b1101);
      check_rows(10, 4'b1011);
      run_to(20);
      check_eq("short_value", {28'd0, kp_if.value}, 32'd0);
      end_test("short_press");

      // r3c0 with a 3-cycle release glitch and a second column closing while
      // held: one strobe only, scan resumes on row 0 after the real release.
      do_reset();
      press(3, 0);
      sb.push_back('{val: 4'hE, cyc: 23});
      run_to(30);
      key_on = 1'b0;
      run_to(33);
      key_on = 1'b1;
      run_to(40);
      extra_low = 4'b0100;
      run_to(45);
      extra_low = 4'h0;
      run_to(50);
      key_on = 1'b0;
      check_rows(57, 4'b0111);
      check_rows(58, 4'b1110);
      run_to(64);
      check_eq("r3c0_value", {28'd0, kp_if.value}, 32'hE);
      end_test("glitch_r3c0");

      // Two columns low on every row: ghosting ignored, scan keeps moving.
      do_reset();
      extra_low = 4'b0011;
      check_rows(0,  4'b1110);
      check_rows(4,  4'b1101);
      check_rows(8,  4'b1011);
      check_rows(12, 4'b0111);
      check_rows(16, 4'b1110);
      run_to(24);
      extra_low = 4'h0;
      end_test("ghost_keys");

      // Accept r0c0, then reset at debounce count 5 of r1c2: pending key
      // dropped, outputs back to reset values at once, no later strobe.
      do_reset();
      press(0, 0);
      sb.push_back('{val: 4'h1, cyc: 11});
      run_to(14);
      key_on = 1'b0;
      check_rows(22, 4'b1101);
      press(1, 2);
      check_rows(30, 4'b1101);
      run_to(31);
      reset = 1'b0;
      #1;
      check_outputs_reset("mid_debounce");
      repeat (3) @(negedge clk);
      key_on = 1'b0;
      kp_if.columns = 4'hF;
      reset = 1'b1;
      cur = 0;
      prev_enable = 1'b0;
      prev_value  = 4'h0;
      check_rows(0, 4'b1110);
      check_rows(4, 4'b1101);
      run_to(30);
      check_eq("post_reset_value", {28'd0, kp_if.value}, 32'd0);
      end_test("reset_mid_debounce");

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_debounce_scanner.md
KEYPAD_DEBOUNCE_SCANNER -- requirements
Module: keypad_debounce_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 48000, clk cycles each row is driven before its columns are sampled (1 ms at 48 MHz).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 960000, clk cycles a key level must hold to count as stable (20 ms at 48 MHz).
REQ-003 SHALL have port clk  input  1  system clock (48 MHz HSOSC); the only clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port columns  input  4  column levels, already two-flop synchronized upstream; active-low (0 = key closed on the driven row).
REQ-006 SHALL have port rows  output  4  row drive, active-low one-hot (exactly one bit 0 at all times).
REQ-007 SHALL have port value  output  4  hex code of the last accepted key.
REQ-008 SHALL have port enable  output  1  single-cycle strobe, high for exactly one clk when value updates.

Function
REQ-009 SHALL map row r / column c (index 0..3) to: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E,0,F,D.
REQ-010 SHALL implement states SCAN, DEBOUNCE_PRESS, HELD, DEBOUNCE_RELEASE.
REQ-011 SCAN: SHALL drive row index i low for SCAN_DIV cycles, then advance i to (i+1) mod 4 (3 wraps to 0).
REQ-012 SCAN: SHALL sample columns only in the last cycle of each row dwell.
REQ-013 SCAN: exactly one column low at sample -> SHALL latch (i, c), freeze rows on row i, clear counter, enter DEBOUNCE_PRESS.
REQ-014 SCAN: zero columns low, or two or more low (ghost/multi-key) -> SHALL ignore and advance the row.
REQ-015 DEBOUNCE_PRESS: SHALL count cycles while latched column c is low; any cycle with c high -> return to SCAN, counter cleared, dwell restarts on row (i+1) mod 4, no strobe.
REQ-016 DEBOUNCE_PRESS: when counter reaches DEBOUNCE_CYCLES with c low throughout, SHALL register value = map(i, c), pulse enable in that same cycle, enter HELD.
REQ-017 Press latency SHALL be exactly DEBOUNCE_CYCLES clk cycles from the SCAN sample cycle to the enable cycle.
REQ-018 HELD: rows SHALL stay frozen on row i; other columns going low SHALL be ignored; no further strobes.
REQ-019 HELD: column c high SHALL enter DEBOUNCE_RELEASE with counter cleared.
REQ-020 DEBOUNCE_RELEASE: c low in any cycle -> SHALL return to HELD with no strobe (bounce absorbed).
REQ-021 DEBOUNCE_RELEASE: c high for DEBOUNCE_CYCLES consecutive cycles -> SHALL enter SCAN on row (i+1) mod 4, fresh dwell.
REQ-022 value SHALL change only in a cycle where enable=1 and SHALL otherwise hold.
REQ-023 enable SHALL never be high on two consecutive cycles; one physical press yields exactly one strobe.
REQ-024 Counters SHALL be sized $clog2 of their parameter and SHALL saturate/clear, never wrap, within a state.
REQ-025 All outputs SHALL be registered; no combinational path from columns to outputs.

Reset
REQ-026 reset=0 SHALL immediately and asynchronously force state=SCAN, row index 0, rows=4'b1110, value=4'h0, enable=0, all counters 0.
REQ-027 reset asserted mid-debounce or mid-hold SHALL discard the pending key with no strobe; after release, scanning restarts at row 0 with a full dwell.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-028 reset low then high, columns=1111 -> rows steps 1110,1101,1011,0111,1110 every 4 cycles; enable never high; value=0.
REQ-029 hold columns=1101 while rows=1011 (r2,c1) -> one enable pulse exactly 8 cycles after the sample; value=8; rows frozen at 1011 until release.
REQ-030 press r0c3 (columns=0111 on rows=1110) for 5 cycles then release -> no enable; value unchanged; scanning resumes at rows=1101.
REQ-031 key r3c0 held, with 3-cycle release glitch inside HELD, then final 8+ cycle release -> exactly one enable, value=E; scanning resumes at rows=1110.
REQ-032 columns=1100 (two keys) on any row -> no capture, row advances normally, no enable.
REQ-033 reset pulsed low at debounce count 5 -> outputs at reset values immediately, no enable afterward until a new full press.
